// File: rtl/ir_nec_rx_ext.sv
// ir_nec_rx_ext - NEC infrared frame receiver.
//
// Purpose:
//   Takes the demodulated IR line (idle high), synchronises and deglitches it,
//   and measures every mark/space width with a single counter. It then decodes
//   32-bit LSB-first NEC frames and verifies the complement bytes. It also
//   recognises repeat codes and reports aborted receptions with a typed cause.
//
// Ports:
//   clk           in   1   system clock
//   rst           in   1   synchronous active-high reset
//   ir_in         in   1   demodulated IR input, asynchronous, idle high
//   addr_out      out  16  address of the last good frame
//   cmd_out       out  8   command of the last good frame
//   frame_valid   out  1   one-cycle pulse, addr_out/cmd_out updated
//   repeat_valid  out  1   one-cycle pulse, valid repeat code received
//   err           out  1   one-cycle pulse, reception aborted
//   err_code      out  2   cause of last err: 0 timing, 1 check, 2 timeout, 3 orphan repeat
//   busy          out  1   high whenever the decoder is not idle

module ir_nec_rx_ext #(
  parameter int unsigned CLK_FREQ   = 50_000_000,
  parameter int unsigned FILTER_CYC = 16,
  parameter int unsigned TOL_PCT    = 25,
  parameter int unsigned EXT_ADDR   = 0,
  parameter int unsigned CHECK_EN   = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ir_in,
  output logic [15:0] addr_out,
  output logic [7:0]  cmd_out,
  output logic        frame_valid,
  output logic        repeat_valid,
  output logic        err,
  output logic [1:0]  err_code,
  output logic        busy
);

  function automatic longint unsigned us2cyc(input longint unsigned us);
    return (us * 64'(CLK_FREQ)) / 64'd1_000_000;
  endfunction

  localparam longint unsigned TMAX_L = us2cyc(64'd12_000);
  localparam longint unsigned IDLE_L = us2cyc(64'd120_000);

  function automatic longint unsigned winLo(input longint unsigned us);
    return (us2cyc(us) * (64'd100 - 64'(TOL_PCT))) / 64'd100;
  endfunction

  // Upper window bounds are clamped to the saturation value so that they
  // always fit in the width counter.
  function automatic longint unsigned winHi(input longint unsigned us);
    longint unsigned v;
    v = (us2cyc(us) * (64'd100 + 64'(TOL_PCT))) / 64'd100;
    return (v > TMAX_L) ? TMAX_L : v;
  endfunction

  localparam int WCW = $clog2(TMAX_L + 64'd1);
  localparam int IDW = $clog2(IDLE_L + 64'd1);
  localparam int FCW = (FILTER_CYC > 1) ? $clog2(FILTER_CYC) : 1;

  localparam logic [WCW-1:0] TMAX   = WCW'(TMAX_L);
  localparam logic [WCW-1:0] W_ONE  = WCW'(1);
  localparam logic [WCW-1:0] LL_LO  = WCW'(winLo(64'd9000));
  localparam logic [WCW-1:0] LL_HI  = WCW'(winHi(64'd9000));
  localparam logic [WCW-1:0] LH_LO  = WCW'(winLo(64'd4500));
  localparam logic [WCW-1:0] LH_HI  = WCW'(winHi(64'd4500));
  localparam logic [WCW-1:0] RP_LO  = WCW'(winLo(64'd2250));
  localparam logic [WCW-1:0] RP_HI  = WCW'(winHi(64'd2250));
  localparam logic [WCW-1:0] BL_LO  = WCW'(winLo(64'd560));
  localparam logic [WCW-1:0] BL_HI  = WCW'(winHi(64'd560));
  localparam logic [WCW-1:0] ZH_LO  = WCW'(winLo(64'd560));
  localparam logic [WCW-1:0] ZH_HI  = WCW'(winHi(64'd560));
  localparam logic [WCW-1:0] OH_LO  = WCW'(winLo(64'd1690));
  localparam logic [WCW-1:0] OH_HI  = WCW'(winHi(64'd1690));
  localparam logic [IDW-1:0] IDLE_MAX = IDW'(IDLE_L);
  localparam logic [IDW-1:0] I_ONE    = IDW'(1);
  localparam logic [FCW-1:0] FLT_LAST = FCW'(FILTER_CYC - 1);
  localparam logic [FCW-1:0] F_ONE    = FCW'(1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_LEADL = 3'd1;
  localparam logic [2:0] S_LEADH = 3'd2;
  localparam logic [2:0] S_BITL  = 3'd3;
  localparam logic [2:0] S_BITH  = 3'd4;
  localparam logic [2:0] S_REPL  = 3'd5;
  localparam logic [2:0] S_CHECK = 3'd6;

  function automatic logic inWin(input logic [WCW-1:0] w,
                                 input logic [WCW-1:0] lo,
                                 input logic [WCW-1:0] hi);
    return (w >= lo) && (w <= hi);
  endfunction

  logic           r_sync1, r_sync2, r_irF, r_irFd;
  logic [FCW-1:0] r_fcnt;
  logic [WCW-1:0] r_wcnt;
  logic [2:0]     r_state;
  logic [5:0]     r_bitCnt;
  logic [31:0]    r_frame;
  logic           r_haveFrame;
  logic [IDW-1:0] r_idleCnt;
  logic [15:0]    r_addr;
  logic [7:0]     r_cmd;
  logic           r_frameValid, r_repeatValid, r_err;
  logic [1:0]     r_errCode;

  logic       w_fall, w_rise, w_edge;
  logic [2:0] w_next;
  logic       w_errNow, w_shift, w_bitVal, w_good, w_rep;
  logic [1:0] w_errSel;
  logic       w_cmdOk, w_addrOk, w_frameOk;

  // Input path: two-flop synchroniser, then a filter that only accepts a new
  // level once it has persisted for FILTER_CYC consecutive cycles. Both edges
  // see the same delay, so measured widths are not distorted.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
      r_irF   <= 1'b1;
      r_irFd  <= 1'b1;
      r_fcnt  <= '0;
    end else begin
      r_sync1 <= ir_in;
      r_sync2 <= r_sync1;
      r_irFd  <= r_irF;
      if (r_sync2 == r_irF) begin
        r_fcnt <= '0;
      end else if (r_fcnt == FLT_LAST) begin
        r_irF  <= r_sync2;
        r_fcnt <= '0;
      end else begin
        r_fcnt <= r_fcnt + F_ONE;
      end
    end
  end

  assign w_fall = r_irFd & ~r_irF;
  assign w_rise = ~r_irFd & r_irF;
  assign w_edge = w_fall | w_rise;

  // Width counter: restarts at every filtered edge and saturates at the
  // timeout value, so its value at an edge strobe is the width just ended.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wcnt <= '0;
    end else if (w_edge) begin
      r_wcnt <= '0;
    end else if (r_wcnt != TMAX) begin
      r_wcnt <= r_wcnt + W_ONE;
    end
  end

  assign w_cmdOk   = (r_frame[23:16] == ~r_frame[31:24]);
  assign w_addrOk  = (EXT_ADDR != 0) || (r_frame[7:0] == ~r_frame[15:8]);
  assign w_frameOk = (CHECK_EN == 0) || (w_cmdOk && w_addrOk);

  // Next-state decode. Each state only reacts to the edge that ends its own
  // pulse; a width outside the state's window aborts with a timing error.
  // Independent of edges, any active state whose pulse has run to saturation
  // aborts with a timeout.
  always_comb begin
    w_next   = r_state;
    w_errNow = 1'b0;
    w_errSel = 2'd0;
    w_shift  = 1'b0;
    w_bitVal = 1'b0;
    w_good   = 1'b0;
    w_rep    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_fall) w_next = S_LEADL;
      end
      S_LEADL: begin
        if (w_rise) begin
          if (inWin(r_wcnt, LL_LO, LL_HI)) w_next = S_LEADH;
          else w_errNow = 1'b1;
        end
      end
      S_LEADH: begin
        if (w_fall) begin
          if (inWin(r_wcnt, LH_LO, LH_HI)) w_next = S_BITL;
          else if (inWin(r_wcnt, RP_LO, RP_HI)) w_next = S_REPL;
          else w_errNow = 1'b1;
        end
      end
      S_BITL: begin
        if (w_rise) begin
          if (!inWin(r_wcnt, BL_LO, BL_HI)) w_errNow = 1'b1;
          else if (r_bitCnt[5]) w_next = S_CHECK;
          else w_next = S_BITH;
        end
      end
      S_BITH: begin
        if (w_fall) begin
          if (inWin(r_wcnt, ZH_LO, ZH_HI)) begin
            w_shift = 1'b1;
            w_next  = S_BITL;
          end else if (inWin(r_wcnt, OH_LO, OH_HI)) begin
            w_shift  = 1'b1;
            w_bitVal = 1'b1;
            w_next   = S_BITL;
          end else begin
            w_errNow = 1'b1;
          end
        end
      end
      S_REPL: begin
        if (w_rise) begin
          w_next = S_IDLE;
          if (!inWin(r_wcnt, BL_LO, BL_HI)) begin
            w_errNow = 1'b1;
          end else if (r_haveFrame) begin
            w_rep = 1'b1;
          end else begin
            w_errNow = 1'b1;
            w_errSel = 2'd3;
          end
        end
      end
      S_CHECK: begin
        w_next = S_IDLE;
        if (w_frameOk) begin
          w_good = 1'b1;
        end else begin
          w_errNow = 1'b1;
          w_errSel = 2'd1;
        end
      end
      default: w_next = S_IDLE;
    endcase
    if ((r_state != S_IDLE) && (r_state != S_CHECK) && !w_edge && (r_wcnt == TMAX)) begin
      w_errNow = 1'b1;
      w_errSel = 2'd2;
    end
    if (w_errNow) w_next = S_IDLE;
  end

  // State, frame shift-in and registered outputs. The bit counter is cleared
  // on the leader-to-data transition so repeat codes never disturb it.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= S_IDLE;
      r_bitCnt      <= '0;
      r_frame       <= '0;
      r_addr        <= '0;
      r_cmd         <= '0;
      r_frameValid  <= 1'b0;
      r_repeatValid <= 1'b0;
      r_err         <= 1'b0;
      r_errCode     <= 2'd0;
    end else begin
      r_state       <= w_next;
      r_frameValid  <= w_good;
      r_repeatValid <= w_rep;
      r_err         <= w_errNow;
      if (w_errNow) r_errCode <= w_errSel;
      if ((r_state == S_LEADH) && (w_next == S_BITL)) begin
        r_bitCnt <= '0;
      end else if (w_shift) begin
        r_frame[r_bitCnt[4:0]] <= w_bitVal;
        r_bitCnt <= r_bitCnt + 6'd1;
      end
      if (w_good) begin
        r_addr <= (EXT_ADDR != 0) ? r_frame[15:0] : {8'h00, r_frame[7:0]};
        r_cmd  <= r_frame[23:16];
      end
    end
  end

  // Repeat permission: granted by a good frame, withdrawn by any error or by
  // a long enough idle period that the repeat could no longer belong to it.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_haveFrame <= 1'b0;
      r_idleCnt   <= '0;
    end else begin
      if (r_state != S_IDLE) r_idleCnt <= '0;
      else if (r_idleCnt != IDLE_MAX) r_idleCnt <= r_idleCnt + I_ONE;
      if (w_errNow) r_haveFrame <= 1'b0;
      else if (w_good) r_haveFrame <= 1'b1;
      else if ((r_state == S_IDLE) && (r_idleCnt == IDLE_MAX)) r_haveFrame <= 1'b0;
    end
  end

  assign addr_out     = r_addr;
  assign cmd_out      = r_cmd;
  assign frame_valid  = r_frameValid;
  assign repeat_valid = r_repeatValid;
  assign err          = r_err;
  assign err_code     = r_errCode;
  assign busy         = (r_state != S_IDLE);

endmodule

// File: tb/tb_ir_nec_rx_ext.sv
// tb_ir_nec_rx_ext - directed bench for ir_nec_rx_ext.
//
// Three receivers share one IR line: dut0 is standard NEC, dut1 has the
// complement checks disabled, dut2 uses 16-bit addresses. A slow 100 kHz
// clock keeps frames short: 1 cycle = 10 us, so the nominal widths are
// leader 900/450, repeat space 225, mark 56, zero space 56, one space 169,
// timeout 1200 and the repeat expiry 12000 cycles.

module tb_ir_nec_rx_ext;

  localparam int unsigned CLK_FREQ = 100_000;
  localparam int LEAD_L = 900;
  localparam int LEAD_H = 450;
  localparam int REP_H  = 225;
  localparam int MARK   = 56;
  localparam int SPACE0 = 56;
  localparam int SPACE1 = 169;
  localparam int TAIL   = 100;

  // Frames as sent on air, byte 0 in bits [7:0].
  localparam logic [31:0] W_T1 = {8'hBA, 8'h45, 8'hFF, 8'h00};
  localparam logic [31:0] W_T4 = {8'hBA, 8'h45, 8'h34, 8'h12};
  localparam logic [31:0] W_T3 = {8'hBB, 8'h45, 8'hFF, 8'h00};

  logic clk  = 1'b0;
  logic rst  = 1'b1;
  logic irIn = 1'b1;

  logic [2:0][15:0] addrOut;
  logic [2:0][7:0]  cmdOut;
  logic [2:0][1:0]  errCode;
  logic [2:0]       frameValid, repeatValid, err, busy;

  int fvCnt[3] = '{0, 0, 0};
  int rvCnt[3] = '{0, 0, 0};
  int erCnt[3] = '{0, 0, 0};
  int multiCnt = 0;
  int fvBase[3];
  int rvBase[3];
  int erBase[3];
  int nAsserts = 0;
  int nFail = 0;

  ir_nec_rx_ext #(.CLK_FREQ(CLK_FREQ)) dut0 (
    .clk(clk), .rst(rst), .ir_in(irIn),
    .addr_out(addrOut[0]), .cmd_out(cmdOut[0]),
    .frame_valid(frameValid[0]), .repeat_valid(repeatValid[0]),
    .err(err[0]), .err_code(errCode[0]), .busy(busy[0])
  );

  ir_nec_rx_ext #(.CLK_FREQ(CLK_FREQ), .CHECK_EN(0)) dut1 (
    .clk(clk), .rst(rst), .ir_in(irIn),
    .addr_out(addrOut[1]), .cmd_out(cmdOut[1]),
    .frame_valid(frameValid[1]), .repeat_valid(repeatValid[1]),
    .err(err[1]), .err_code(errCode[1]), .busy(busy[1])
  );

  ir_nec_rx_ext #(.CLK_FREQ(CLK_FREQ), .EXT_ADDR(1)) dut2 (
    .clk(clk), .rst(rst), .ir_in(irIn),
    .addr_out(addrOut[2]), .cmd_out(cmdOut[2]),
    .frame_valid(frameValid[2]), .repeat_valid(repeatValid[2]),
    .err(err[2]), .err_code(errCode[2]), .busy(busy[2])
  );

  always #5 clk = ~clk;

  // Pulse counters, sampled mid-cycle; also note any cycle with more than
  // one of the three pulses high on the same receiver.
  always @(negedge clk) begin
    for (int k = 0; k < 3; k++) begin
      if (frameValid[k]) fvCnt[k]++;
      if (repeatValid[k]) rvCnt[k]++;
      if (err[k]) erCnt[k]++;
      if ((int'(frameValid[k]) + int'(repeatValid[k]) + int'(err[k])) > 1) multiCnt++;
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nAsserts++;
    assert (obs === exp) else begin
      nFail++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic takeSnapshot();
    for (int k = 0; k < 3; k++) begin
      fvBase[k] = fvCnt[k];
      rvBase[k] = rvCnt[k];
      erBase[k] = erCnt[k];
    end
  endtask

  task automatic hold(input logic lvl, input int n);
    irIn = lvl;
    repeat (n) @(negedge clk);
  endtask

  task automatic sendLeader(input bit isRepeat);
    hold(1'b0, LEAD_L);
    hold(1'b1, isRepeat ? REP_H : LEAD_H);
  endtask

  // Glitches sit well clear of the real edges so the filter swallows them
  // without shifting either edge.
  task automatic sendBit(input bit b, input bit glitch);
    int sp;
    sp = b ? SPACE1 : SPACE0;
    if (glitch) begin
      hold(1'b0, 23);
      hold(1'b1, 10);
      hold(1'b0, MARK - 33);
      hold(1'b1, (sp - 10) / 2);
      hold(1'b0, 10);
      hold(1'b1, sp - 10 - (sp - 10) / 2);
    end else begin
      hold(1'b0, MARK);
      hold(1'b1, sp);
    end
  endtask

  task automatic applyStimulus(input logic [31:0] word, input bit glitch);
    sendLeader(1'b0);
    for (int i = 0; i < 32; i++) sendBit(word[i], glitch);
    hold(1'b0, MARK);
    hold(1'b1, TAIL);
  endtask

  task automatic sendRepeat();
    sendLeader(1'b1);
    hold(1'b0, MARK);
    hold(1'b1, TAIL);
  endtask

  initial begin
    logic [31:0] word;
    word = W_T1;
    $display("[TB] starting ir_nec_rx_ext bench");

    // Reset state
    repeat (4) @(negedge clk);
    checkOutput("rst addr", 32'(addrOut[0]), 32'h0);
    checkOutput("rst cmd", 32'(cmdOut[0]), 32'h0);
    checkOutput("rst busy", 32'(busy), 32'h0);
    checkOutput("rst errcode", 32'(errCode[0]), 32'h0);
    checkOutput("rst pulses", 32'(frameValid | repeatValid | err), 32'h0);
    rst = 1'b0;
    hold(1'b1, 50);

    // Repeat code with no frame seen yet
    takeSnapshot();
    sendRepeat();
    checkOutput("orphan err", 32'(erCnt[0] - erBase[0]), 32'd1);
    checkOutput("orphan code", 32'(errCode[0]), 32'd3);
    checkOutput("orphan rv", 32'(rvCnt[0] - rvBase[0]), 32'd0);

    // Basic frame 00 FF 45 BA
    takeSnapshot();
    applyStimulus(W_T1, 1'b0);
    checkOutput("t1 fv", 32'(fvCnt[0] - fvBase[0]), 32'd1);
    checkOutput("t1 addr", 32'(addrOut[0]), 32'h0000);
    checkOutput("t1 cmd", 32'(cmdOut[0]), 32'h45);
    checkOutput("t1 err", 32'(erCnt[0] - erBase[0]), 32'd0);
    checkOutput("t1 busy", 32'(busy[0]), 32'd0);
    checkOutput("t1 ext addr", 32'(addrOut[2]), 32'hFF00);

    // Repeat 40 ms after the frame
    hold(1'b1, 4000 - TAIL);
    takeSnapshot();
    sendRepeat();
    checkOutput("rep rv", 32'(rvCnt[0] - rvBase[0]), 32'd1);
    checkOutput("rep fv", 32'(fvCnt[0] - fvBase[0]), 32'd0);
    checkOutput("rep err", 32'(erCnt[0] - erBase[0]), 32'd0);
    checkOutput("rep cmd", 32'(cmdOut[0]), 32'h45);

    // After 130 ms of idle the repeat no longer belongs to a frame
    hold(1'b1, 13000);
    takeSnapshot();
    sendRepeat();
    checkOutput("expired err", 32'(erCnt[0] - erBase[0]), 32'd1);
    checkOutput("expired code", 32'(errCode[0]), 32'd3);
    checkOutput("expired rv", 32'(rvCnt[0] - rvBase[0]), 32'd0);

    // 6 ms leader mark, well below the 6.75 ms lower bound
    takeSnapshot();
    hold(1'b0, 600);
    hold(1'b1, TAIL);
    checkOutput("short lead err", 32'(erCnt[0] - erBase[0]), 32'd1);
    checkOutput("short lead code", 32'(errCode[0]), 32'd0);

    // Line stuck low after bit 5: timeout roughly 1200 cycles after the edge
    takeSnapshot();
    sendLeader(1'b0);
    for (int i = 0; i < 6; i++) sendBit(word[i], 1'b0);
    hold(1'b0, 1100);
    checkOutput("stuck early err", 32'(erCnt[0] - erBase[0]), 32'd0);
    checkOutput("stuck busy", 32'(busy[0]), 32'd1);
    hold(1'b0, 200);
    checkOutput("stuck err", 32'(erCnt[0] - erBase[0]), 32'd1);
    checkOutput("stuck code", 32'(errCode[0]), 32'd2);
    checkOutput("stuck idle", 32'(busy[0]), 32'd0);
    checkOutput("stuck cmd", 32'(cmdOut[0]), 32'h45);
    hold(1'b1, TAIL);

    // Reset pulsed during the space of bit 10
    takeSnapshot();
    sendLeader(1'b0);
    for (int i = 0; i < 10; i++) sendBit(word[i], 1'b0);
    hold(1'b0, MARK);
    hold(1'b1, 60);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checkOutput("midrst addr", 32'(addrOut[0]), 32'h0);
    checkOutput("midrst cmd", 32'(cmdOut[0]), 32'h0);
    checkOutput("midrst busy", 32'(busy), 32'h0);
    checkOutput("midrst code", 32'(errCode[0]), 32'h0);
    checkOutput("midrst pulses", 32'(frameValid | repeatValid | err), 32'h0);
    hold(1'b1, 1500);
    checkOutput("midrst no err", 32'(erCnt[0] - erBase[0]), 32'd0);
    checkOutput("midrst no fv", 32'(fvCnt[0] - fvBase[0]), 32'd0);

    // Same frame as before with a 10-cycle glitch in every mark and space
    takeSnapshot();
    applyStimulus(W_T1, 1'b1);
    checkOutput("glitch fv", 32'(fvCnt[0] - fvBase[0]), 32'd1);
    checkOutput("glitch addr", 32'(addrOut[0]), 32'h0000);
    checkOutput("glitch cmd", 32'(cmdOut[0]), 32'h45);
    checkOutput("glitch err", 32'(erCnt[0] - erBase[0]), 32'd0);

    // Extended address 12 34 45 BA
    takeSnapshot();
    applyStimulus(W_T4, 1'b0);
    checkOutput("ext std err", 32'(erCnt[0] - erBase[0]), 32'd1);
    checkOutput("ext std code", 32'(errCode[0]), 32'd1);
    checkOutput("ext std cmd", 32'(cmdOut[0]), 32'h45);
    checkOutput("ext nochk fv", 32'(fvCnt[1] - fvBase[1]), 32'd1);
    checkOutput("ext nochk addr", 32'(addrOut[1]), 32'h0012);
    checkOutput("ext fv", 32'(fvCnt[2] - fvBase[2]), 32'd1);
    checkOutput("ext addr", 32'(addrOut[2]), 32'h3412);
    checkOutput("ext cmd", 32'(cmdOut[2]), 32'h45);

    // cmd_n corrupted to BB
    takeSnapshot();
    applyStimulus(W_T3, 1'b0);
    checkOutput("bad cmdn err", 32'(erCnt[0] - erBase[0]), 32'd1);
    checkOutput("bad cmdn code", 32'(errCode[0]), 32'd1);
    checkOutput("bad cmdn fv", 32'(fvCnt[0] - fvBase[0]), 32'd0);
    checkOutput("nochk fv", 32'(fvCnt[1] - fvBase[1]), 32'd1);
    checkOutput("nochk cmd", 32'(cmdOut[1]), 32'h45);
    checkOutput("nochk addr", 32'(addrOut[1]), 32'h0000);
    checkOutput("ext bad err", 32'(erCnt[2] - erBase[2]), 32'd1);
    checkOutput("ext bad hold addr", 32'(addrOut[2]), 32'h3412);

    checkOutput("one pulse per cycle", 32'(multiCnt), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", nAsserts, nFail);
    $finish;
  end

endmodule
